mips_multicycle_ctrl: RTL

- Multi-cycle main control FSM for the non-pipelined MIPS datapath.
- Sits directly upstream of the ALU. Decodes the instruction register and drives alu_cntrl, ALU operand select, memory, register-file and PC controls.
- Consumes the ALU zero flag to resolve beq.
- Sequences the registered ALU with a fixed two-cycle EXEC window. Result and zero are consumed only after that window.

---
 rtl/mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle main control FSM for a non-pipelined MIPS datapath.
// Moore outputs are registered from the next state; ir_write/pc_write carry input qualifiers.
module mips_multicycle_ctrl #(
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [3:0]       alu_cntrl,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StEx1    = 4'd2,
        StEx2    = 4'd3,
        StBr     = 4'd4,
        StMem    = 4'd5,
        StMemWb  = 4'd6,
        StAluWb  = 4'd7,
        StJump   = 4'd8,
        StTrap   = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        ClsR    = 3'd0,
        ClsAddi = 3'd1,
        ClsLw   = 3'd2,
        ClsSw   = 3'd3,
        ClsBeq  = 3'd4,
        ClsJ    = 3'd5,
        ClsBad  = 3'd6
    } cls_e;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0011;
    localparam logic [3:0] AluMul = 4'b0100;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpMul   = 6'h1C;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic [3:0]        alu_q, alu_d, dec_alu;
    logic              retire;
    logic [CNT_W-1:0]  instr_count_q;

    logic [1:0]        pc_src_q, pc_src_d;
    logic              iord_q, iord_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              reg_write_q, reg_write_d;
    logic              reg_dst_q, reg_dst_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              alu_src_b_q, alu_src_b_d;
    logic [3:0]        alu_cntrl_q, alu_cntrl_d;
    logic              illegal_q, illegal_d;

    logic [5:0]        opcode, funct;
    logic              unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];

    // Instruction class and ALU op, captured in DECODE and held through the EX window.
    always_comb begin
        dec_cls = ClsBad;
        dec_alu = AluAdd;
        case (opcode)
            OpRtype: begin
                case (funct)
                    6'h20:   begin dec_cls = ClsR; dec_alu = AluAdd; end
                    6'h22:   begin dec_cls = ClsR; dec_alu = AluSub; end
                    6'h24:   begin dec_cls = ClsR; dec_alu = AluAnd; end
                    6'h25:   begin dec_cls = ClsR; dec_alu = AluOr;  end
                    default: dec_cls = ClsBad;
                endcase
            end
            OpMul: begin
                if (MUL_EN && funct == 6'h02) begin
                    dec_cls = ClsR;
                    dec_alu = AluMul;
                end
            end
            OpLw:    dec_cls = ClsLw;
            OpSw:    dec_cls = ClsSw;
            OpAddi:  dec_cls = ClsAddi;
            OpBeq:   begin dec_cls = ClsBeq; dec_alu = AluSub; end
            OpJ:     dec_cls = ClsJ;
            default: dec_cls = ClsBad;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                cls_d = dec_cls;
                alu_d = dec_alu;
                case (dec_cls)
                    ClsJ:    state_d = StJump;
                    ClsBad:  state_d = StTrap;
                    default: state_d = StEx1;
                endcase
            end
            StEx1: state_d = StEx2;
            StEx2: begin
                case (cls_q)
                    ClsBeq:       state_d = StBr;
                    ClsLw, ClsSw: state_d = StMem;
                    default:      state_d = StAluWb;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (cls_q == ClsLw) begin
                        state_d = StMemWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StBr, StMemWb, StAluWb, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    // Moore outputs for the state being entered, so they are valid from the first cycle there.
    always_comb begin
        pc_src_d     = 2'b00;
        iord_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_b_d  = 1'b0;
        alu_cntrl_d  = AluAdd;
        illegal_d    = 1'b0;
        case (state_d)
            StFetch: mem_read_d = 1'b1;
            StEx1, StEx2: begin
                alu_cntrl_d = alu_d;
                alu_src_b_d = (cls_d == ClsAddi) || (cls_d == ClsLw) || (cls_d == ClsSw);
            end
            StBr: pc_src_d = 2'b01;
            StMem: begin
                iord_d      = 1'b1;
                mem_read_d  = (cls_d == ClsLw);
                mem_write_d = (cls_d == ClsSw);
            end
            StMemWb: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            StAluWb: begin
                reg_write_d = 1'b1;
                reg_dst_d   = (cls_d == ClsR);
            end
            StJump:  pc_src_d  = 2'b10;
            StTrap:  illegal_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            cls_q         <= ClsBad;
            alu_q         <= AluAdd;
            instr_count_q <= '0;
            pc_src_q      <= 2'b00;
            iord_q        <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_dst_q     <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            alu_src_b_q   <= 1'b0;
            alu_cntrl_q   <= AluAdd;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            alu_q         <= alu_d;
            if (retire) instr_count_q <= instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            pc_src_q      <= pc_src_d;
            iord_q        <= iord_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            reg_dst_q     <= reg_dst_d;
            mem_to_reg_q  <= mem_to_reg_d;
            alu_src_b_q   <= alu_src_b_d;
            alu_cntrl_q   <= alu_cntrl_d;
            illegal_q     <= illegal_d;
        end
    end

    // Fetch commit and branch resolution are qualified by live inputs.
    always_comb begin
        ir_write = (state_q == StFetch) && mem_ready;
        pc_write = ((state_q == StFetch) && mem_ready)
                 || ((state_q == StBr) && zero)
                 || (state_q == StJump);
    end

    assign pc_src      = pc_src_q;
    assign iord        = iord_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign reg_write   = reg_write_q;
    assign reg_dst     = reg_dst_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign alu_src_b   = alu_src_b_q;
    assign alu_cntrl   = alu_cntrl_q;
    assign illegal     = illegal_q;
    assign state       = state_q;
    assign instr_count = instr_count_q;

    no_mem_and_reg_write: assert property (@(posedge clk) !(mem_write && reg_write));

endmodule
